// File: rtl/fft_frame_loader_pkg.sv
// Shared constants for the fft frame loader: FSM encoding, default sizes and
// the width helper used for the word counter and FIFO pointers.
package fft_frame_loader_pkg;

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_PAD   = 2'd1;
   localparam logic [1:0] ST_START = 2'd2;
   localparam logic [1:0] ST_WAIT  = 2'd3;

   localparam int DEF_FRAME_SIZE = 2;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_FIFO_DEPTH = 4;

   // Index width for n entries; never below 1 so a one-entry range stays legal.
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// AXI-Stream data/handshake bundle used on both sides of the frame loader.
interface fft_frame_loader_if
   import fft_frame_loader_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/fft_frame_loader_axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module axis_sync_fifo
   import fft_frame_loader_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_WIDTH + 1,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = width_of(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W:0]   wr_ptr_r;
   logic [PTR_W:0]   rd_ptr_r;
   logic             push_s;
   logic             pop_s;

   // Overflow/underflow requests are dropped rather than corrupting pointers.
   assign push_s = push && !full;
   assign pop_s  = pop && !empty;
   assign empty  = (wr_ptr_r == rd_ptr_r);
   assign full   = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                   (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
   assign rdata  = mem_r[rd_ptr_r[PTR_W-1:0]];

   // Pointer update; simultaneous push and pop keeps occupancy unchanged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
         end
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[PTR_W-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/fft_frame_loader.sv
// Frames an unframed sample stream into fixed-size fft input frames, pads
// short blocks with zeros, pulses start and holds off until the fft is done.
module fft_frame_loader
   import fft_frame_loader_pkg::*;
#(
   parameter int FRAME_SIZE = DEF_FRAME_SIZE,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                s00_axi_aclk,
   input  logic                s00_axi_aresetn,
   fft_frame_loader_if.slave   s00_axis,
   fft_frame_loader_if.master  m00_axis,
   output logic                start,
   input  logic                fft_done,
   output logic                frame_short,
   output logic                busy
);

   localparam int                WCNT_W    = width_of(FRAME_SIZE);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FRAME_SIZE - 1);

   logic [1:0]            state_r;
   logic [1:0]            state_nxt_s;
   logic [WCNT_W-1:0]     wcnt_r;
   logic                  start_r;
   logic                  busy_r;
   logic                  frame_short_r;
   logic                  full_s;
   logic                  empty_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  hs_s;
   logic                  at_last_s;
   logic                  m_valid_s;
   logic [DATA_WIDTH-1:0] m_data_s;
   logic [DATA_WIDTH:0]   head_s;

   assign s00_axis.tready = s00_axi_aresetn && !full_s;
   assign push_s          = s00_axis.tvalid && s00_axis.tready;

   axis_sync_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (s00_axi_aclk),
      .rst_n (s00_axi_aresetn),
      .push  (push_s),
      .wdata ({s00_axis.tdata, s00_axis.tlast}),
      .pop   (pop_s),
      .rdata (head_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Downstream beat source: FIFO head while loading, zeros while padding.
   always_comb begin
      m_valid_s = 1'b0;
      m_data_s  = '0;
      case (state_r)
         ST_LOAD: begin
            if (!empty_s) begin
               m_valid_s = 1'b1;
               m_data_s  = head_s[DATA_WIDTH:1];
            end else begin
               m_valid_s = 1'b0;
               m_data_s  = '0;
            end
         end
         ST_PAD: begin
            m_valid_s = 1'b1;
            m_data_s  = '0;
         end
         default: begin
            m_valid_s = 1'b0;
            m_data_s  = '0;
         end
      endcase
   end

   assign at_last_s       = (wcnt_r == WCNT_LAST);
   assign hs_s            = m_valid_s && m00_axis.tready;
   assign pop_s           = hs_s && (state_r == ST_LOAD);
   assign m00_axis.tvalid = m_valid_s;
   assign m00_axis.tdata  = m_data_s;
   assign m00_axis.tlast  = m_valid_s && at_last_s;

   // Frame sequencing; an upstream tlast on the final slot needs no padding.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_LOAD: begin
            if (hs_s && at_last_s) begin
               state_nxt_s = ST_START;
            end else if (hs_s && head_s[0]) begin
               state_nxt_s = ST_PAD;
            end else begin
               state_nxt_s = ST_LOAD;
            end
         end
         ST_PAD: begin
            if (hs_s && at_last_s) begin
               state_nxt_s = ST_START;
            end else begin
               state_nxt_s = ST_PAD;
            end
         end
         ST_START: begin
            state_nxt_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (fft_done) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         default: begin
            state_nxt_s = ST_LOAD;
         end
      endcase
   end

   // State, word counter and registered status outputs.
   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         state_r       <= ST_LOAD;
         wcnt_r        <= '0;
         start_r       <= 1'b0;
         busy_r        <= 1'b0;
         frame_short_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         start_r <= (state_nxt_s == ST_START);
         busy_r  <= (state_nxt_s == ST_START) || (state_nxt_s == ST_WAIT);
         if (hs_s) begin
            wcnt_r <= at_last_s ? '0 : wcnt_r + WCNT_W'(1);
         end else if (state_r == ST_START) begin
            wcnt_r <= '0;
         end else begin
            wcnt_r <= wcnt_r;
         end
         if (pop_s && !at_last_s && head_s[0]) begin
            frame_short_r <= 1'b1;
         end else begin
            frame_short_r <= frame_short_r;
         end
      end
   end

   assign start       = start_r;
   assign busy        = busy_r;
   assign frame_short = frame_short_r;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader: a stream-level model queues the
// expected fft beats per accepted sample, a monitor pops and compares them.
module tb_fft_frame_loader;

   localparam int FS = 2;
   localparam int DW = 32;
   localparam int FD = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   logic aresetn;
   logic start;
   logic fft_done;
   logic frame_short;
   logic busy;

   fft_frame_loader_if #(.DATA_WIDTH(DW)) s_if ();
   fft_frame_loader_if #(.DATA_WIDTH(DW)) m_if ();

   fft_frame_loader #(
      .FRAME_SIZE (FS),
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (FD)
   ) dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (aresetn),
      .s00_axis        (s_if),
      .m00_axis        (m_if),
      .start           (start),
      .fft_done        (fft_done),
      .frame_short     (frame_short),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   int    checks   = 0;
   int    failures = 0;
   beat_t exp_q[$];
   int    pos_m     = 0;
   bit    exp_short = 1'b0;
   bit    waiting_m = 1'b0;
   bit    last_hs_m = 1'b0;
   bit    rst_prev_low = 1'b0;
   bit    prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic  prev_last;

   int rdy_mode     = 0;
   int done_delay   = 10;
   int done_cnt     = 0;
   bit auto_done    = 1'b1;
   bit done_on_start = 1'b0;
   int poke_req     = 0;
   int poke_ack     = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: each accepted sample fills the next frame slot; an
   // upstream tlast before the final slot zero-fills the rest of the frame.
   initial begin
      beat_t b;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            pos_m     = 0;
            exp_short = 1'b0;
         end else if (s_if.tvalid && s_if.tready) begin
            b.data = s_if.tdata;
            b.last = (pos_m == FS - 1);
            exp_q.push_back(b);
            if (pos_m == FS - 1) begin
               pos_m = 0;
            end else if (s_if.tlast) begin
               for (int p = pos_m + 1; p < FS; p++) begin
                  b.data = '0;
                  b.last = (p == FS - 1);
                  exp_q.push_back(b);
               end
               pos_m     = 0;
               exp_short = 1'b1;
            end else begin
               pos_m++;
            end
         end
      end
   end

   // Output monitor: beats, start timing, busy, and hold-off while computing.
   initial begin
      beat_t b;
      bit    exp_start;
      bit    hs;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            if (rst_prev_low) begin
               check("rst_s_tready", s_if.tready, 0);
               check("rst_m_tvalid", m_if.tvalid, 0);
               check("rst_m_tlast", m_if.tlast, 0);
               check("rst_m_tdata", m_if.tdata, 0);
               check("rst_start", start, 0);
               check("rst_busy", busy, 0);
               check("rst_frame_short", frame_short, 0);
            end
            exp_q.delete();
            waiting_m    = 1'b0;
            last_hs_m    = 1'b0;
            prev_stall   = 1'b0;
            rst_prev_low = 1'b1;
         end else begin
            rst_prev_low = 1'b0;
            exp_start = last_hs_m;
            check("start", start, exp_start);
            check("busy", busy, exp_start || waiting_m);
            if (exp_start || waiting_m) begin
               check("valid_while_busy", m_if.tvalid, 0);
            end
            if (prev_stall) begin
               check("hold_valid", m_if.tvalid, 1);
               check("hold_data", m_if.tdata, prev_data);
               check("hold_last", m_if.tlast, prev_last);
            end
            hs = m_if.tvalid && m_if.tready;
            last_hs_m = 1'b0;
            if (hs) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_beat", m_if.tvalid, 0);
               end else begin
                  b = exp_q.pop_front();
                  check("beat_data", m_if.tdata, b.data);
                  check("beat_last", m_if.tlast, b.last);
                  last_hs_m = b.last;
               end
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
            prev_last  = m_if.tlast;
            if (waiting_m && fft_done) waiting_m = 1'b0;
            if (exp_start) waiting_m = 1'b1;
         end
      end
   end

   // fft stand-in: done after a delay, on request, or (for test) during start.
   initial begin
      fft_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         fft_done = 1'b0;
         if (poke_req != poke_ack) begin
            fft_done = 1'b1;
            poke_ack++;
         end
         if (start === 1'b1) begin
            if (done_on_start) fft_done = 1'b1;
            else if (auto_done) done_cnt = done_delay;
         end else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) fft_done = 1'b1;
         end
      end
   end

   // Downstream ready: 0 always on, 1 random, 2 held low.
   initial begin
      m_if.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: m_if.tready = 1'b1;
            2: m_if.tready = 1'b0;
            default: m_if.tready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic l);
      bit acc = 1'b0;
      s_if.tdata  = d;
      s_if.tlast  = l;
      s_if.tvalid = 1'b1;
      for (int n = 0; n < 500 && !acc; n++) begin
         @(negedge clk);
         acc = s_if.tready;
         @(posedge clk);
      end
      #1;
      s_if.tvalid = 1'b0;
      if (!acc) check("send_timeout", s_if.tready, 1);
   endtask

   task automatic drain();
      int quiet = 0;
      for (int n = 0; n < 3000 && quiet < 2; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !last_hs_m && !waiting_m && !busy) quiet++;
         else quiet = 0;
      end
      check("drain_queue_empty", exp_q.size(), 0);
      check("drain_idle", busy, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DW-1:0] w5;
      aresetn     = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tlast  = 1'b0;
      idle(3);
      aresetn = 1'b1;
      idle(1);

      // pi, -pi as one exact frame
      send(32'h40490FDB, 1'b0);
      send(32'hC0490FDB, 1'b1);
      drain();
      check("short_after_exact", frame_short, exp_short);

      // single sample block is padded
      send(32'h42F6E979, 1'b1);
      drain();
      check("short_after_pad", frame_short, exp_short);

      // backpressure: FIFO fills after four words
      rdy_mode = 2;
      idle(1);
      for (int i = 0; i < 4; i++) send(32'h1000_0000 + i, 1'b0);
      w5 = 32'h1000_0004;
      s_if.tdata  = w5;
      s_if.tlast  = 1'b1;
      s_if.tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("full_tready", s_if.tready, 0);
      end
      @(posedge clk);
      #1;
      rdy_mode = 0;
      send(w5, 1'b1);
      drain();

      // two frames streamed, second buffered during the first computation
      done_delay = 10;
      send(32'hAAAA_0001, 1'b0);
      send(32'hBBBB_0002, 1'b0);
      send(32'hCCCC_0003, 1'b0);
      send(32'hDDDD_0004, 1'b0);
      drain();

      // reset after one word of a frame has gone out
      send(32'h5555_0000, 1'b0);
      idle(1);
      aresetn = 1'b0;
      idle(2);
      aresetn = 1'b1;
      idle(1);
      send(32'h7777_1111, 1'b0);
      send(32'h8888_2222, 1'b0);
      drain();
      check("short_after_reset", frame_short, exp_short);

      // fft_done in LOAD and in START must be ignored
      auto_done = 1'b0;
      poke_req++;
      idle(3);
      done_on_start = 1'b1;
      send(32'h0123_4567, 1'b0);
      send(32'h89AB_CDEF, 1'b0);
      idle(20);
      @(negedge clk);
      check("wait_holds", busy, 1);
      @(posedge clk);
      #1;
      done_on_start = 1'b0;
      poke_req++;
      drain();
      auto_done = 1'b1;

      // randomized traffic with random backpressure and fft latency
      rdy_mode = 1;
      for (int i = 0; i < 150; i++) begin
         done_delay = $urandom_range(1, 12);
         send($urandom, (i == 149) ? 1'b1 : ($urandom_range(0, 4) == 0));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      drain();
      check("short_after_random", frame_short, exp_short);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
